// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the byte-serial memory arbiter:
//   - access size codes (byte / half / word; code 3 behaves as word)
//   - FSM state encodings (IDLE / XFER / DONE)
//   - grant-owner encoding (instruction fetch vs. data port)
//   - size_nbytes(): number of bytes moved for a size code
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  // Access size codes
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Grant owner encoding
  localparam logic OWNER_IF   = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  // Bytes per access; the unused code 3 falls through to a word access.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_ld_ext.sv
// -----------------------------------------------------------------------------
// mem_ld_ext
// Load result extension: zero- or sign-extends the low 1, 2 or 4 bytes of a
// raw little-endian word according to the access size code.
// Ports:
//   size_i    in  2   access size code (3 treated as word)
//   signed_i  in  1   1 = sign-extend from bit 8N-1, 0 = zero-extend
//   raw_i     in  32  assembled raw load bytes
//   ext_o     out 32  extended result
// -----------------------------------------------------------------------------
module mem_ld_ext
  import mem_arbiter_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] raw_i,
  output logic [31:0] ext_o
);

  always_comb begin
    ext_o = raw_i;
    case (size_i)
      SIZE_BYTE: ext_o = {{24{signed_i & raw_i[7]}},  raw_i[7:0]};
      SIZE_HALF: ext_o = {{16{signed_i & raw_i[15]}}, raw_i[15:0]};
      default:   ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction-fetch port and a load/store port onto a single
// byte-wide synchronous RAM. Each granted access is moved one byte per cycle
// (little-endian), then a one-cycle done pulse is raised for the owner.
//
// Build option: MEM_ARBITER_DATA_PRIO_EN
//   defined   -> simultaneous requests always go to the data port
//   undefined -> simultaneous requests alternate (round-robin on last grant)
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_req_i / if_addr_i          fetch request (always unsigned word read)
//   if_data_o / if_done_o         fetched word, one-cycle completion pulse
//   mem_req_i, mem_we_i,          load/store request, store select,
//   mem_size_i, mem_signed_i,     size code, sign-extend select,
//   mem_addr_i, mem_wdata_i       byte address, store data
//   mem_rdata_o / mem_done_o      extended load result, completion pulse
//   ram_addr_o, ram_we_o,         byte RAM address, write enable,
//   ram_dout_o, ram_din_i         write data, read data (1-cycle latency)
//   busy_o                        high whenever not IDLE (stall request)
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MEM_SIZE_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic [31:0]           if_data_o,
  output logic                  if_done_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [MEM_SIZE_W-1:0] mem_size_i,
  input  logic                  mem_signed_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_done_o,
  output logic [ADDR_W-1:0]     ram_addr_o,
  output logic                  ram_we_o,
  output logic [7:0]            ram_dout_o,
  input  logic [7:0]            ram_din_i,
  output logic                  busy_o
);

  logic [1:0]        r_state;
  logic              r_owner;
  logic              r_last_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_base;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [31:0]       r_wdata;
  logic [2:0]        r_k;
  logic [31:0]       r_raw;
  logic [31:0]       r_if_data;
  logic [31:0]       r_mem_rdata;

  logic              w_accept;
  logic              w_grant_data;
  logic [1:0]        w_mem_size;
  logic [2:0]        w_nbytes;
  logic              w_in_xfer;
  logic              w_addr_active;
  logic              w_capture;
  logic [1:0]        w_cap_idx;
  logic              w_xfer_end;
  logic [31:0]       w_raw_next;
  logic [31:0]       w_ld_ext;
  logic [7:0]        w_wbyte;

  assign w_mem_size = 2'(mem_size_i);
  assign w_accept   = (r_state == ST_IDLE) && (if_req_i || mem_req_i);

`ifdef MEM_ARBITER_DATA_PRIO_EN
  assign w_grant_data = mem_req_i;
`else
  // Data wins a tie only when fetch had the previous grant; last_grant
  // resets to data so the first tie after reset goes to fetch.
  assign w_grant_data = mem_req_i && (!if_req_i || (r_last_grant == OWNER_IF));
`endif

  assign w_nbytes      = size_nbytes(r_size);
  assign w_in_xfer     = (r_state == ST_XFER);
  // Loads spend one extra XFER cycle (k == N) waiting for the last byte;
  // no address is presented during that cycle.
  assign w_addr_active = w_in_xfer && (r_k < w_nbytes);

  assign ram_addr_o = w_addr_active ? (r_base + ADDR_W'(r_k)) : '0;
  assign ram_we_o   = w_addr_active && r_we;
  assign w_wbyte    = 8'(r_wdata >> {r_k[1:0], 3'b000});
  assign ram_dout_o = ram_we_o ? w_wbyte : 8'h00;

  // Read data lags its address by one cycle, so at counter k we receive
  // byte k-1.
  assign w_capture = w_in_xfer && !r_we && (r_k != 3'd0);
  assign w_cap_idx = 2'(r_k - 3'd1);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_raw_byte
      assign w_raw_next[8*gi +: 8] = (w_capture && (w_cap_idx == 2'(gi)))
                                     ? ram_din_i : r_raw[8*gi +: 8];
    end
  endgenerate

  assign w_xfer_end = w_in_xfer &&
                      (r_we ? (r_k == 3'(w_nbytes - 3'd1)) : (r_k == w_nbytes));

  // Extension works on the merged word so the result is ready on the same
  // edge that captures the final byte.
  mem_ld_ext u_ld_ext (
    .size_i   (r_size),
    .signed_i (r_signed),
    .raw_i    (w_raw_next),
    .ext_o    (w_ld_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWNER_DATA;
      r_last_grant <= OWNER_DATA;
      r_we         <= 1'b0;
      r_base       <= '0;
      r_size       <= SIZE_BYTE;
      r_signed     <= 1'b0;
      r_wdata      <= '0;
      r_k          <= '0;
      r_raw        <= '0;
      r_if_data    <= '0;
      r_mem_rdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state      <= ST_XFER;
            r_k          <= '0;
            r_raw        <= '0;
            r_owner      <= w_grant_data ? OWNER_DATA : OWNER_IF;
            r_last_grant <= w_grant_data ? OWNER_DATA : OWNER_IF;
            if (w_grant_data) begin
              r_base   <= mem_addr_i;
              r_size   <= w_mem_size;
              r_signed <= mem_signed_i;
              r_we     <= mem_we_i;
              r_wdata  <= mem_wdata_i;
            end else begin
              r_base   <= if_addr_i;
              r_size   <= SIZE_WORD;
              r_signed <= 1'b0;
              r_we     <= 1'b0;
              r_wdata  <= '0;
            end
          end
        end
        ST_XFER: begin
          r_raw <= w_raw_next;
          r_k   <= r_k + 3'd1;
          if (w_xfer_end) begin
            r_state <= ST_DONE;
            if (!r_we) begin
              if (r_owner == OWNER_IF) r_if_data   <= w_raw_next;
              else                     r_mem_rdata <= w_ld_ext;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_k     <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign if_data_o   = r_if_data;
  assign mem_rdata_o = r_mem_rdata;
  assign if_done_o   = (r_state == ST_DONE) && (r_owner == OWNER_IF);
  assign mem_done_o  = (r_state == ST_DONE) && (r_owner == OWNER_DATA);
  assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter with a behavioural byte RAM and a
// reference model that derives expected bus activity and load results from
// a shadow copy of memory contents.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam logic OWN_IF   = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_done_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic        mem_signed_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_done_o;
  logic [31:0] ram_addr_o;
  logic        ram_we_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] exp_ram [logic [31:0]];

  mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_data_o    (if_data_o),
    .if_done_o    (if_done_o),
    .mem_req_i    (mem_req_i),
    .mem_we_i     (mem_we_i),
    .mem_size_i   (mem_size_i),
    .mem_signed_i (mem_signed_i),
    .mem_addr_i   (mem_addr_i),
    .mem_wdata_i  (mem_wdata_i),
    .mem_rdata_o  (mem_rdata_o),
    .mem_done_o   (mem_done_o),
    .ram_addr_o   (ram_addr_o),
    .ram_we_o     (ram_we_o),
    .ram_dout_o   (ram_dout_o),
    .ram_din_i    (ram_din_i),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // Byte RAM with registered read.
  always @(posedge clk) begin
    ram_din_i <= ram.exists(ram_addr_o) ? ram[ram_addr_o] : 8'h00;
    if (ram_we_o) ram[ram_addr_o] = ram_dout_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_rd(input logic [31:0] a);
    return exp_ram.exists(a) ? exp_ram[a] : 8'h00;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    ram[a]     = d;
    exp_ram[a] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete access from an idle arbiter with no competing request.
  task automatic run_access(input string name, input bit is_fetch, input bit we,
                            input logic [1:0] size, input bit sgn,
                            input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    longint unsigned v;
    logic [31:0] exp_data;
    n = (is_fetch || size >= 2) ? 4 : ((size == 2'd1) ? 2 : 1);
    if (is_fetch) we = 1'b0;
    v = 0;
    for (int i = 0; i < n; i++) v |= longint'(exp_rd(addr + 32'(i))) << (8 * i);
    if (!is_fetch && sgn && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
    exp_data = v[31:0];

    @(negedge clk);
    if (is_fetch) begin
      if_req_i  = 1'b1;
      if_addr_i = addr;
    end else begin
      mem_req_i    = 1'b1;
      mem_we_i     = we;
      mem_size_i   = size;
      mem_signed_i = sgn;
      mem_addr_i   = addr;
      mem_wdata_i  = wdata;
    end
    @(posedge clk);
    @(negedge clk);
    // Fields latched at grant; changing them now must have no effect.
    if_addr_i    = $urandom;
    mem_addr_i   = $urandom;
    mem_wdata_i  = $urandom;
    mem_size_i   = 2'($urandom_range(0, 3));
    mem_signed_i = 1'($urandom_range(0, 1));
    mem_we_i     = 1'($urandom_range(0, 1));

    for (int i = 0; i < n; i++) begin
      total++;
      if (ram_addr_o !== addr + 32'(i)) begin
        bad++;
        $display("FAIL %s addr[%0d]: got %h want %h", name, i, ram_addr_o, addr + 32'(i));
      end
      total++;
      if (ram_we_o !== we) begin
        bad++;
        $display("FAIL %s we[%0d]: got %b want %b", name, i, ram_we_o, we);
      end
      if (we) begin
        total++;
        if (ram_dout_o !== wdata[8*i +: 8]) begin
          bad++;
          $display("FAIL %s dout[%0d]: got %h want %h", name, i, ram_dout_o, wdata[8*i +: 8]);
        end
        exp_ram[addr + 32'(i)] = wdata[8*i +: 8];
      end
      @(negedge clk);
    end

    if (!we) begin
      total++;
      if (busy_o !== 1'b1 || if_done_o !== 1'b0 || mem_done_o !== 1'b0) begin
        bad++;
        $display("FAIL %s capture_cycle: busy=%b if_done=%b mem_done=%b want 1/0/0",
                 name, busy_o, if_done_o, mem_done_o);
      end
      @(negedge clk);
    end

    // Completion cycle
    total++;
    if ((is_fetch ? if_done_o : mem_done_o) !== 1'b1 ||
        (is_fetch ? mem_done_o : if_done_o) !== 1'b0) begin
      bad++;
      $display("FAIL %s done: if_done=%b mem_done=%b want %b/%b",
               name, if_done_o, mem_done_o, is_fetch, !is_fetch);
    end
    total++;
    if (ram_we_o !== 1'b0 || ram_addr_o !== 32'h0 || ram_dout_o !== 8'h00) begin
      bad++;
      $display("FAIL %s ram_idle_in_done: we=%b addr=%h dout=%h want 0/0/0",
               name, ram_we_o, ram_addr_o, ram_dout_o);
    end
    if (!we) begin
      total++;
      if ((is_fetch ? if_data_o : mem_rdata_o) !== exp_data) begin
        bad++;
        $display("FAIL %s data: got %h want %h", name,
                 is_fetch ? if_data_o : mem_rdata_o, exp_data);
      end
    end
    if_req_i  = 1'b0;
    mem_req_i = 1'b0;
    @(negedge clk);
    total++;
    if (if_done_o !== 1'b0 || mem_done_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL %s after_done: if_done=%b mem_done=%b busy=%b want 0/0/0",
               name, if_done_o, mem_done_o, busy_o);
    end
    $display("txn %s fetch=%0b we=%0b size=%0d sgn=%0b addr=%h wdata=%h model=%h",
             name, is_fetch, we, size, sgn, addr, wdata, exp_data);
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    if_req_i     = 1'b0;
    if_addr_i    = '0;
    mem_req_i    = 1'b0;
    mem_we_i     = 1'b0;
    mem_size_i   = '0;
    mem_signed_i = 1'b0;
    mem_addr_i   = '0;
    mem_wdata_i  = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy_o, if_done_o, mem_done_o, ram_we_o} !== 4'b0000 ||
        ram_addr_o !== 32'h0 || ram_dout_o !== 8'h00 ||
        if_data_o !== 32'h0 || mem_rdata_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b%b we=%b addr=%h dout=%h if_data=%h rdata=%h want all 0",
               busy_o, if_done_o, mem_done_o, ram_we_o, ram_addr_o, ram_dout_o, if_data_o, mem_rdata_o);
    end
    rst = 1'b0;
    $display("txn reset");
  endtask

  task automatic test_fetch_word();
    poke(32'h100, 8'h13);
    poke(32'h101, 8'h05);
    poke(32'h102, 8'h10);
    poke(32'h103, 8'h00);
    run_access("fetch_0x100", 1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    total++;
    if (if_data_o !== 32'h00100513) begin
      bad++;
      $display("FAIL fetch_word_const: got %h want 00100513", if_data_o);
    end
  endtask

  task automatic test_store_half();
    run_access("store_half_0x2001", 1'b0, 1'b1, 2'd1, 1'b0, 32'h2001, 32'hABCD1234);
    total++;
    if (ram[32'h2001] !== 8'h34 || ram[32'h2002] !== 8'h12 || ram.exists(32'h2003)) begin
      bad++;
      $display("FAIL store_half_ram: got %h %h third_written=%0b want 34 12 0",
               ram[32'h2001], ram[32'h2002], ram.exists(32'h2003));
    end
  endtask

  task automatic test_sign_ext();
    poke(32'h400, 8'hF0);
    poke(32'h401, 8'h80);
    run_access("ld_byte_signed_F0", 1'b0, 1'b0, 2'd0, 1'b1, 32'h400, 32'h0);
    total++;
    if (mem_rdata_o !== 32'hFFFFFFF0) begin
      bad++;
      $display("FAIL sign_byte_F0: got %h want FFFFFFF0", mem_rdata_o);
    end
    run_access("ld_byte_unsigned_F0", 1'b0, 1'b0, 2'd0, 1'b0, 32'h400, 32'h0);
    total++;
    if (mem_rdata_o !== 32'h000000F0) begin
      bad++;
      $display("FAIL zero_byte_F0: got %h want 000000F0", mem_rdata_o);
    end
    run_access("ld_byte_signed_80", 1'b0, 1'b0, 2'd0, 1'b1, 32'h401, 32'h0);
    run_access("ld_half_signed", 1'b0, 1'b0, 2'd1, 1'b1, 32'h400, 32'h0);
    run_access("ld_size3_word", 1'b0, 1'b0, 2'd3, 1'b1, 32'h400, 32'h0);
    // Fetch result must survive unrelated data-port completions.
    total++;
    if (if_data_o !== 32'h00100513) begin
      bad++;
      $display("FAIL fetch_hold: got %h want 00100513", if_data_o);
    end
  endtask

  task automatic test_wrap();
    poke(32'hFFFFFFFE, 8'h11);
    poke(32'hFFFFFFFF, 8'h22);
    poke(32'h00000000, 8'h33);
    poke(32'h00000001, 8'h44);
    run_access("ld_word_wrap", 1'b0, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0);
  endtask

  task automatic test_reset_mid_store();
    @(negedge clk);
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b1;
    mem_size_i  = 2'd2;
    mem_addr_i  = 32'h5000;
    mem_wdata_i = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b1;
    mem_req_i = 1'b0;
    #1;
    total++;
    if ({busy_o, if_done_o, mem_done_o, ram_we_o} !== 4'b0000 ||
        ram_addr_o !== 32'h0 || ram_dout_o !== 8'h00 ||
        if_data_o !== 32'h0 || mem_rdata_o !== 32'h0) begin
      bad++;
      $display("FAIL mid_store_reset: busy=%b done=%b%b we=%b addr=%h dout=%h if_data=%h rdata=%h want all 0",
               busy_o, if_done_o, mem_done_o, ram_we_o, ram_addr_o, ram_dout_o, if_data_o, mem_rdata_o);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_ram[32'h5000] = 8'hEF;
    $display("txn reset_mid_store");
    run_access("ld_after_abort", 1'b0, 1'b0, 2'd0, 1'b0, 32'h5000, 32'h0);
  endtask

  task automatic test_arbitration();
    logic last;
    logic want;
    logic got;
    int   cnt;
    do_reset();
    @(negedge clk);
    if_req_i     = 1'b1;
    if_addr_i    = 32'h100;
    mem_req_i    = 1'b1;
    mem_we_i     = 1'b0;
    mem_size_i   = 2'd0;
    mem_signed_i = 1'b0;
    mem_addr_i   = 32'h400;
    last         = OWN_DATA;
    for (int g = 0; g < 3; g++) begin
`ifdef MEM_ARBITER_DATA_PRIO_EN
      want = OWN_DATA;
`else
      want = (last == OWN_DATA) ? OWN_IF : OWN_DATA;
`endif
      last = want;
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!if_done_o && !mem_done_o && cnt < 20);
      total++;
      if (cnt >= 20) begin
        bad++;
        $display("FAIL arb_grant%0d: no done within 20 cycles, want owner %0d", g, want);
      end else begin
        got = mem_done_o ? OWN_DATA : OWN_IF;
        if (got !== want) begin
          bad++;
          $display("FAIL arb_grant%0d: got owner %0d want %0d", g, got, want);
        end
        $display("txn arb_grant%0d owner=%0d", g, got);
      end
      if (g < 2) begin
        if (mem_done_o) mem_req_i = 1'b0;
        else            if_req_i  = 1'b0;
        @(negedge clk);
        if_req_i  = 1'b1;
        mem_req_i = 1'b1;
      end else begin
        if_req_i  = 1'b0;
        mem_req_i = 1'b0;
      end
    end
    cnt = 0;
    while (busy_o && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL arb_settle: busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 64; i++) poke(32'h3000 + 32'(i), 8'($urandom));
    for (int t = 0; t < 30; t++) begin
      bit          f;
      bit          w;
      logic [1:0]  s;
      bit          sg;
      logic [31:0] a;
      f  = ($urandom_range(0, 3) == 0);
      w  = 1'($urandom_range(0, 1));
      s  = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = 32'h3000 + 32'($urandom_range(0, 60));
      run_access($sformatf("rand%0d", t), f, w, s, sg, a, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_word();
    test_store_half();
    test_sign_ext();
    test_wrap();
    test_reset_mid_store();
    test_arbitration();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
